// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and helpers for the write-back stage
//
// Holds the load-size encodings, the queue occupancy state enum and the
// queue entry struct. Entry fields are sized for the widest supported
// configuration (DATA_W up to 32, ADDR_W up to 8). Narrower builds
// zero-extend into the entry and truncate on the way out.
package wb_pkg;

  localparam int WB_MAX_DATA_W = 32;
  localparam int WB_MAX_ADDR_W = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    WB_EMPTY = 2'd0,
    WB_ONE   = 2'd1,
    WB_FULL  = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [WB_MAX_DATA_W-1:0] data;
    logic [WB_MAX_ADDR_W-1:0] rd;
    logic                     regwrite;
  } wb_entry_t;

  // An entry only touches the register file if it writes and is not r0.
  function automatic logic entry_writes(input wb_entry_t e);
    return e.regwrite && (e.rd != '0);
  endfunction

endpackage

// File: rtl/wb_load_fmt.sv
// rtl/wb_load_fmt.sv - combinational load size/sign formatter
//
// Ports:
//   raw         in  DATA_W  raw data-memory read word
//   size        in  2       SZ_BYTE / SZ_HALF / SZ_WORD (11 treated as word)
//   is_unsigned in  1       1 = zero-extend, 0 = sign-extend
//   data        out DATA_W  formatted load data
module wb_load_fmt
  import wb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] byte_ext;
  logic [DATA_W-1:0] half_ext;

  // A byte load on an 8-bit datapath is the whole word.
  if (DATA_W > 8) begin : g_byte_ext
    assign byte_ext = {{(DATA_W-8){~is_unsigned & raw[7]}}, raw[7:0]};
  end else begin : g_byte_full
    assign byte_ext = raw;
  end

  // A half load on an 8- or 16-bit datapath is the whole word.
  if (DATA_W > 16) begin : g_half_ext
    assign half_ext = {{(DATA_W-16){~is_unsigned & raw[15]}}, raw[15:0]};
  end else begin : g_half_full
    assign half_ext = raw;
  end

  always_comb begin
    data = raw;
    case (size)
      SZ_BYTE: data = byte_ext;
      SZ_HALF: data = half_ext;
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/write_back_stage_p.sv
// rtl/write_back_stage_p.sv - MIPS write-back stage with 2-entry retire queue
//
// Optional feature macro: WB_FWD_EN (adds fwd_valid/fwd_addr/fwd_data).
//
// Ports:
//   clk, reset (sync, active-high), flush (drops all buffered entries)
//   in_valid/in_ready      retiring instruction handshake from MEM
//   in_alu, in_mem         ALU result, raw load word
//   in_memtoreg, in_size, in_unsigned   load select and formatting
//   in_regwrite, in_rd     destination control
//   rf_ready               register file can take a write this cycle
//   rf_we/rf_waddr/rf_wdata  register-file write port (head entry)
//   retire_cnt             instructions popped since reset (wraps)
//   fwd_valid/fwd_addr/fwd_data  youngest pending write (WB_FWD_EN only)
module write_back_stage_p
  import wb_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic              in_memtoreg,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic              in_regwrite,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  retire_cnt
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  wb_state_e         state_q, state_d;
  wb_entry_t         head_q, tail_q, new_entry;
  logic [DATA_W-1:0] load_data;
  logic [CNT_W-1:0]  cnt_q;
  logic              head_valid, push, pop;

  wb_load_fmt #(.DATA_W(DATA_W)) u_load_fmt (
    .raw        (in_mem),
    .size       (in_size),
    .is_unsigned(in_unsigned),
    .data       (load_data)
  );

  always_comb begin
    new_entry          = '0;
    new_entry.data     = WB_MAX_DATA_W'(in_memtoreg ? load_data : in_alu);
    new_entry.rd       = WB_MAX_ADDR_W'(in_rd);
    new_entry.regwrite = in_regwrite;
  end

  // in_ready depends on registered state only.
  assign head_valid = (state_q != WB_EMPTY);
  assign in_ready   = (state_q != WB_FULL);
  assign push       = in_valid & in_ready;
  // Non-writing entries retire regardless of rf_ready.
  assign pop        = head_valid & (~entry_writes(head_q) | rf_ready);

  assign rf_we      = head_valid & entry_writes(head_q) & rf_ready;
  assign rf_waddr   = head_valid ? ADDR_W'(head_q.rd) : '0;
  assign rf_wdata   = head_valid ? DATA_W'(head_q.data) : '0;
  assign retire_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_EMPTY: if (push) state_d = WB_ONE;
      WB_ONE: begin
        if (push && !pop)      state_d = WB_FULL;
        else if (!push && pop) state_d = WB_EMPTY;
      end
      WB_FULL:  if (pop) state_d = WB_ONE;
      default:  state_d = WB_EMPTY;
    endcase
    if (flush) state_d = WB_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= WB_EMPTY;
    else       state_q <= state_d;
  end

  // Slot movement; contents of invalid slots are don't-care because every
  // output is gated by the occupancy state.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (!flush) begin
      case (state_q)
        WB_EMPTY: if (push) head_q <= new_entry;
        WB_ONE: begin
          if (push && pop) head_q <= new_entry;
          else if (push)   tail_q <= new_entry;
        end
        WB_FULL:  if (pop) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  // A pop in a flush cycle still retires its instruction.
  always_ff @(posedge clk) begin
    if (reset)    cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + CNT_W'(1);
  end

`ifdef WB_FWD_EN
  // Youngest pending register write wins: tail first when full, then head.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_addr  = '0;
    fwd_data  = '0;
    if (state_q == WB_FULL && entry_writes(tail_q)) begin
      fwd_valid = 1'b1;
      fwd_addr  = ADDR_W'(tail_q.rd);
      fwd_data  = DATA_W'(tail_q.data);
    end else if (head_valid && entry_writes(head_q)) begin
      fwd_valid = 1'b1;
      fwd_addr  = ADDR_W'(head_q.rd);
      fwd_data  = DATA_W'(head_q.data);
    end
  end
`endif

endmodule

// File: doc/write_back_stage_p.md
Name: write_back_stage_p

Overview:
- Parametrised successor of the 8-bit write-back register for the MIPS pipeline.
- Accepts retiring instructions from the MEM stage over a valid/ready handshake, selects ALU result or formatted load data, and buffers them in a 2-entry queue.
- Drives the register-file write port, which may stall via rf_ready. Suppresses writes to r0 and counts retired instructions.

Parameters:
- DATA_W, 8, datapath width in bits (8, 16 or 32).
- ADDR_W, 3, register address width.
- CNT_W, 16, retire counter width.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high; clears all state
- flush  in  1  synchronous, discards all buffered entries
- in_valid  in  1  MEM stage holds a retiring instruction
- in_ready  out  1  stage can accept this cycle
- in_alu  in  DATA_W  ALU result
- in_mem  in  DATA_W  raw data-memory read word
- in_memtoreg  in  1  1 = load data, 0 = ALU result
- in_size  in  2  load size: 00 byte, 01 half, 10 full word, 11 reserved (treated as full)
- in_unsigned  in  1  1 = zero-extend load, 0 = sign-extend
- in_regwrite  in  1  instruction writes a register
- in_rd  in  ADDR_W  destination register
- rf_ready  in  1  register file accepts a write this cycle
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- retire_cnt  out  CNT_W  instructions retired since reset

Behaviour:
- Transfer in: in_valid & in_ready at a rising edge.
- in_ready = (occupancy < 2).
  - Registered from state; no combinational path from rf_ready or in_valid.
- Data formatting on entry:
  - in_memtoreg = 0: stored data = in_alu.
  - in_memtoreg = 1: in_mem formatted by in_size/in_unsigned from its low bits.
    - byte = bits [7:0] extended to DATA_W.
    - half = bits [15:0] extended (full word if DATA_W = 8).
    - full = in_mem unchanged.
- Each entry stores data, rd and regwrite.
- Head entry:
  - rf_waddr/rf_wdata always show the head entry; they are 0 when empty.
  - rf_we = head valid & regwrite & (rd != 0) & rf_ready.
- Pop:
  - Head valid with regwrite = 1 and rd != 0: pops when rf_ready = 1.
  - Head valid with regwrite = 0 or rd = 0: pops unconditionally (no write).
- Latency: an entry accepted at edge N is at the head at N if the queue was empty, so its earliest rf_we is in cycle N+1 (1 cycle).
- State machine, on occupancy:
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - ONE stays ONE on simultaneous push and pop; the new entry becomes head next cycle, and order is preserved.
  - FULL -> ONE on pop; no push is possible in FULL.
- retire_cnt increments by 1 on every pop (write or not). It wraps from 2^CNT_W-1 to 0.
- flush:
  - Next state EMPTY; any same-cycle push is dropped.
  - A same-cycle pop still counts, and its rf_we is still issued.
- reset:
  - Dominates flush.
  - Outputs next cycle: in_ready = 1, rf_we = 0, rf_waddr = 0, rf_wdata = 0, retire_cnt = 0.
  - Reset mid-stall discards buffered entries without writing.

Optional Feature:
- Macro WB_FWD_EN.
- Defined: adds outputs fwd_valid (1), fwd_addr (ADDR_W) and fwd_data (DATA_W), combinational from the youngest valid entry with regwrite = 1 and rd != 0.
  - fwd_valid = 0 if no such entry.
  - Used for the EX-stage bypass of stalled write-backs.
- Undefined: the ports are absent and there is no extra logic.

Decomposition:
- Package wb_pkg:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD.
  - Occupancy state enum (WB_EMPTY, WB_ONE, WB_FULL).
  - Entry struct (data, rd, regwrite).
- One sub-module, wb_load_fmt: combinational load size/sign formatter, parametrised by DATA_W.

Test Plan:
- Reset, then in_alu = 8'h5A, rd = 3, regwrite = 1, rf_ready = 1 -> next cycle rf_we = 1, rf_waddr = 3, rf_wdata = 8'h5A; retire_cnt = 1.
- Load, DATA_W = 16, in_mem = 16'h0080:
  - size = byte, signed -> rf_wdata = 16'hFF80.
  - size = byte, unsigned -> 16'h0080.
- rf_ready = 0 while 3 back-to-back pushes are offered -> in_ready drops after 2 accepted. rf_ready = 1 -> writes drain in order; the third is accepted once occupancy falls below 2.
- rd = 0 with regwrite = 1, and rd = 5 with regwrite = 0 -> no rf_we for either; retire_cnt advances by 2 even with rf_ready = 0.
- FULL queue, assert flush together with in_valid -> EMPTY next cycle, no writes, in_ready = 1. Reset asserted while FULL -> all outputs 0, retire_cnt = 0.
- CNT_W = 4, retire 17 instructions -> retire_cnt = 1.
- With WB_FWD_EN, stall holding rd = 2 then rd = 4 -> fwd_addr = 4 with that entry's data.
